// File: rtl/if_inst_buffer.sv
// Fetch-to-decode decoupling FIFO: holds fetch beats in order,
// flushes on redirect, and keeps id_allow_in off the fetch path.
module if_inst_buffer #(
  parameter int DEPTH = 4,
  parameter int BUS_W = 97
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_allow_in,
  input  logic [BUS_W-1:0]             in_bus,
  output logic                         out_valid,
  input  logic                         id_allow_in,
  output logic [BUS_W-1:0]             out_bus,
  input  logic                         redirect_valid,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [BUS_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [CW-1:0]    count;
  logic             full;
  logic             push;
  logic             pop;

  assign full        = (count == CW'(DEPTH));
  assign in_allow_in = redirect_valid | ~full;
  assign out_valid   = (count != '0) & ~redirect_valid;
  assign out_bus     = out_valid ? mem[rp] : '0;
  assign occupancy   = count;

  assign push = in_valid & in_allow_in & ~redirect_valid;
  assign pop  = out_valid & id_allow_in;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= in_bus;
  end

endmodule

// File: tb/tb_if_inst_buffer.sv
// Self-checking bench for if_inst_buffer: directed scenarios plus
// a randomized run against a queue reference model.
module tb_if_inst_buffer;

  localparam int DEPTH = 4;
  localparam int BUS_W = 97;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_allow_in;
  logic [BUS_W-1:0] in_bus;
  logic             out_valid;
  logic             id_allow_in;
  logic [BUS_W-1:0] out_bus;
  logic             redirect_valid;
  logic [CW-1:0]    occupancy;

  int n_chk  = 0;
  int n_pass = 0;

  logic [BUS_W-1:0] q[$];

  if_inst_buffer #(.DEPTH(DEPTH), .BUS_W(BUS_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_allow_in    (in_allow_in),
    .in_bus         (in_bus),
    .out_valid      (out_valid),
    .id_allow_in    (id_allow_in),
    .out_bus        (out_bus),
    .redirect_valid (redirect_valid),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of entries, capacity DEPTH.
  function automatic logic m_ov();
    return (q.size() != 0) && !redirect_valid;
  endfunction

  function automatic logic m_ai();
    return redirect_valid || (q.size() < DEPTH);
  endfunction

  function automatic logic [BUS_W-1:0] m_bus();
    if (m_ov()) return q[0];
    return '0;
  endfunction

  function automatic logic [CW-1:0] m_occ();
    return CW'(q.size());
  endfunction

  function automatic logic [BUS_W-1:0] mk(input logic [31:0] pc);
    logic [31:0] inst;
    inst = $urandom;
    return {1'b0, pc + 32'd4, pc, inst};
  endfunction

  function automatic logic [BUS_W-1:0] rnd_bus();
    logic [31:0] a, b, c;
    logic        t;
    a = $urandom; b = $urandom; c = $urandom;
    t = 1'($urandom_range(0, 1));
    return {t, a, b, c};
  endfunction

  task automatic drive(input logic iv, input logic [BUS_W-1:0] bus,
                       input logic ia, input logic rd, input logic rs);
    @(negedge clk);
    in_valid       = iv;
    in_bus         = bus;
    id_allow_in    = ia;
    redirect_valid = rd;
    reset          = rs;
    #1;
  endtask

  task automatic tick();
    logic             ps, pp, fl;
    logic [BUS_W-1:0] b;
    ps = in_valid && m_ai() && !redirect_valid;
    pp = m_ov() && id_allow_in;
    fl = reset || redirect_valid;
    b  = in_bus;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (ps) q.push_back(b);
    end
  endtask

  task automatic test_reset();
    drive(0, '0, 0, 0, 1); tick();
    drive(0, '0, 0, 0, 1); tick();
    drive(0, '0, 0, 0, 0);
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL rst_ov got %b want 0", out_valid);
    else n_pass++;
    n_chk++;
    if (out_bus !== '0) $display("FAIL rst_bus got %h want 0", out_bus);
    else n_pass++;
    n_chk++;
    if (in_allow_in !== 1'b1) $display("FAIL rst_ai got %b want 1", in_allow_in);
    else n_pass++;
    n_chk++;
    if (occupancy !== '0) $display("FAIL rst_occ got %0d want 0", occupancy);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [BUS_W-1:0] a;
    a = {1'b0, 32'h8000_0004, 32'h8000_0000, 32'h0280_0421};
    drive(1, a, 1, 0, 0);
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL single_push_ov got %b want 0", out_valid);
    else n_pass++;
    tick();
    drive(0, '0, 1, 0, 0);
    n_chk++;
    if (out_valid !== 1'b1) $display("FAIL single_ov got %b want 1", out_valid);
    else n_pass++;
    n_chk++;
    if (out_bus !== a) $display("FAIL single_bus got %h want %h", out_bus, a);
    else n_pass++;
    tick();
    drive(0, '0, 1, 0, 0);
    n_chk++;
    if (occupancy !== '0) $display("FAIL single_occ got %0d want 0", occupancy);
    else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    logic [BUS_W-1:0] e[5];
    for (int i = 0; i < 5; i++) e[i] = mk(32'h8000_0000 + 32'(4 * i));
    for (int i = 0; i < 5; i++) begin
      drive(1, e[i], 0, 0, 0);
      n_chk++;
      if (in_allow_in !== (i < 4)) $display("FAIL bp_ai%0d got %b want %b", i, in_allow_in, (i < 4));
      else n_pass++;
      tick();
    end
    drive(1, e[4], 1, 0, 0);
    n_chk++;
    if (in_allow_in !== 1'b0) $display("FAIL bp_full_pop_ai got %b want 0", in_allow_in);
    else n_pass++;
    n_chk++;
    if (out_bus !== e[0]) $display("FAIL bp_out0 got %h want %h", out_bus, e[0]);
    else n_pass++;
    tick();
    drive(1, e[4], 1, 0, 0);
    n_chk++;
    if (in_allow_in !== 1'b1) $display("FAIL bp_ai_rise got %b want 1", in_allow_in);
    else n_pass++;
    tick();
    for (int i = 2; i < 5; i++) begin
      drive(0, '0, 1, 0, 0);
      n_chk++;
      if (out_valid !== 1'b1 || out_bus[63:32] !== 32'h8000_0000 + 32'(4 * i))
        $display("FAIL bp_order%0d got pc %h want %h", i, out_bus[63:32], 32'h8000_0000 + 32'(4 * i));
      else n_pass++;
      tick();
    end
    drive(0, '0, 1, 0, 0);
    n_chk++;
    if (occupancy !== '0) $display("FAIL bp_drain got %0d want 0", occupancy);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] want;
    for (int k = 0; k <= 20; k++) begin
      if (k < 20) drive(1, mk(32'h8000_1000 + 32'(4 * k)), 1, 0, 0);
      else        drive(0, '0, 1, 0, 0);
      if (k > 0) begin
        want = 32'h8000_1000 + 32'(4 * (k - 1));
        n_chk++;
        if (out_valid !== 1'b1 || out_bus[63:32] !== want || occupancy !== CW'(1))
          $display("FAIL stream%0d got ov %b pc %h occ %0d want 1 %h 1", k, out_valid, out_bus[63:32], occupancy, want);
        else n_pass++;
      end
      tick();
    end
    drive(0, '0, 0, 0, 0);
    n_chk++;
    if (occupancy !== '0) $display("FAIL stream_end got %0d want 0", occupancy);
    else n_pass++;
  endtask

  task automatic test_redirect();
    logic [BUS_W-1:0] b;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, mk(32'h9000_0000 + 32'(4 * i)), 0, 0, 0);
      tick();
    end
    drive(1, mk(32'h9999_0000), 1, 1, 0);
    n_chk++;
    if (out_valid !== 1'b0 || out_bus !== '0 || in_allow_in !== 1'b1)
      $display("FAIL redir_cyc got ov %b bus %h ai %b want 0 0 1", out_valid, out_bus, in_allow_in);
    else n_pass++;
    tick();
    drive(1, mk(32'h9999_0004), 1, 1, 0);
    n_chk++;
    if (occupancy !== '0 || out_valid !== 1'b0)
      $display("FAIL redir_twice got occ %0d ov %b want 0 0", occupancy, out_valid);
    else n_pass++;
    tick();
    b = mk(32'h1c00_0000);
    drive(1, b, 1, 0, 0);
    n_chk++;
    if (occupancy !== '0) $display("FAIL redir_empty got %0d want 0", occupancy);
    else n_pass++;
    tick();
    drive(0, '0, 1, 0, 0);
    n_chk++;
    if (out_valid !== 1'b1 || out_bus !== b) $display("FAIL redir_b got %h want %h", out_bus, b);
    else n_pass++;
    tick();
    drive(0, '0, 1, 0, 0);
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL redir_stale got ov %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [BUS_W-1:0] c;
    for (int i = 0; i < 3; i++) begin
      drive(1, mk(32'hA000_0000 + 32'(4 * i)), 0, 0, 0);
      tick();
    end
    drive(1, mk(32'hAAAA_0000), 1, 0, 1);
    tick();
    c = mk(32'hB000_0000);
    drive(1, c, 0, 0, 0);
    n_chk++;
    if (out_valid !== 1'b0 || out_bus !== '0 || in_allow_in !== 1'b1 || occupancy !== '0)
      $display("FAIL mid_rst got ov %b bus %h ai %b occ %0d want 0 0 1 0", out_valid, out_bus, in_allow_in, occupancy);
    else n_pass++;
    tick();
    drive(0, '0, 1, 0, 0);
    n_chk++;
    if (out_bus !== c) $display("FAIL mid_rst_first got %h want %h", out_bus, c);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic aa, iv, ia, rd, rs;
    for (int n = 0; n < 10000; n++) begin
      iv = ($urandom_range(0, 99) < 70);
      ia = ($urandom_range(0, 99) < 60);
      rd = ($urandom_range(0, 99) < 3);
      rs = ($urandom_range(0, 999) == 0);
      drive(iv, rnd_bus(), ia, rd, rs);
      n_chk++;
      if (out_valid !== m_ov() || out_bus !== m_bus())
        $display("FAIL rnd_out@%0d got %b %h want %b %h", n, out_valid, out_bus, m_ov(), m_bus());
      else n_pass++;
      n_chk++;
      if (occupancy !== m_occ() || in_allow_in !== m_ai())
        $display("FAIL rnd_occ@%0d got %0d ai %b want %0d ai %b", n, occupancy, in_allow_in, m_occ(), m_ai());
      else n_pass++;
      aa = in_allow_in;
      id_allow_in = ~ia;
      #1;
      n_chk++;
      if (in_allow_in !== aa) $display("FAIL rnd_comb@%0d got %b want %b", n, in_allow_in, aa);
      else n_pass++;
      id_allow_in = ia;
      #1;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_bus = '0;
    id_allow_in = 1'b0; redirect_valid = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_redirect();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/if_inst_buffer.md
# if_inst_buffer

Decoupling instruction buffer between the fetch stage and the decode stage. Each fetch-stage beat (predicted-taken flag, predicted next PC, PC, instruction) is stored in a small circular FIFO and presented to decode in order. It absorbs decode back-pressure without a combinational path from `id_allow_in` back into the fetch PC/SRAM logic. All contents are discarded in one cycle on a decode-issued redirect.

## Interface

Parameters:
- `DEPTH`, default 4: number of entries; power of two, ≥ 2.
- `BUS_W`, default 97: entry width, equal to `IF_TO_ID_BUS_WIDTH`. The entry layout is `{pred_br_taken[96], pred_next_pc[95:64], pc[63:32], inst[31:0]}` and is carried opaquely.

Ports:
- `clk`  in  1: clock. One clock domain only.
- `reset`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: fetch-side entry valid (fetch stage `if_to_id_valid`).
- `in_allow_in`  out  1: buffer can accept an entry this cycle (drives fetch `id_allow_in`).
- `in_bus`  in  BUS_W: fetch-side entry (`if_to_id_bus`).
- `out_valid`  out  1: head entry valid toward decode.
- `id_allow_in`  in  1: decode accepts the head this cycle.
- `out_bus`  out  BUS_W: head entry.
- `redirect_valid`  in  1: flush request, the same signal fetch decodes from `id_to_if_bus`.
- `occupancy`  out  $clog2(DEPTH+1): number of valid entries.

## Operation

- Storage is `DEPTH` × `BUS_W` registers, with a write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits and wrapping modulo `DEPTH`. `count` is a separate register, 0..DEPTH.
- Combinational outputs:
  - `full = (count == DEPTH)`
  - `in_allow_in = redirect_valid | !full`. This depends only on registered state and `redirect_valid`, never on `id_allow_in`.
  - `out_valid = (count != 0) & !redirect_valid`
  - `out_bus = out_valid ? mem[rp] : 0`
  - `occupancy = count`
- Push: `in_valid & in_allow_in & !redirect_valid`. Writes `mem[wp] <= in_bus` and increments `wp`.
- Pop: `out_valid & id_allow_in`. Increments `rp`.
- `count` next value is `count + push − pop`.
- Flush: when `redirect_valid` = 1, the next state is `wp = rp = count = 0`. Push and pop are suppressed in that cycle. The storage array is not cleared.
- Reset: `wp = rp = count = 0`. The array is not reset.
- Entries leave in arrival order. No entry is duplicated, dropped (except by flush), or reordered.

## Timing

- Values immediately after reset: `out_valid` = 0, `out_bus` = 0, `in_allow_in` = 1, `occupancy` = 0.
- Latency: an entry pushed on edge N is visible on `out_bus` with `out_valid` = 1 in cycle N+1. There is no empty-bypass path.
- Throughput: 1 push and 1 pop per cycle sustained once `count` ≥ 1.
- Empty with push: push only. Decode sees the entry next cycle.
- Full with pop: the pop happens, but the push is refused (`in_allow_in` = 0 for that whole cycle). `in_allow_in` rises the cycle after the pop.
- `count` = DEPTH−1 with push and no pop: becomes full, and `in_allow_in` = 0 in the next cycle.
- Pointer wrap: after `DEPTH−1`, `wp` and `rp` go to 0. A full buffer has `wp == rp`; `count` disambiguates full from empty.
- Redirect in the same cycle as `in_valid` and/or `id_allow_in`:
  - Nothing is pushed or popped.
  - `out_valid` = 0 that cycle.
  - The next cycle is empty.
- Redirect on consecutive cycles: the buffer stays empty throughout. The first push is accepted on the first cycle with `redirect_valid` = 0.
- Reset asserted mid-operation: the buffer is empty at the next edge. Reset has priority over redirect, push and pop.
- `in_bus` is sampled only on push edges. `out_bus` is stable while `out_valid` = 1 and `id_allow_in` = 0.

## Test plan

- Reset, then push A (`pc=0x80000000`, `inst=0x02800421`) with `id_allow_in` = 1:
  - `out_valid` = 0 on the push cycle.
  - Next cycle: `out_valid` = 1 and `out_bus` = A.
  - The cycle after: `occupancy` = 0.
- Hold `id_allow_in` = 0 and offer 5 entries (PCs `0x80000000` … `0x80000010`):
  - The first 4 are accepted, and `in_allow_in` = 0 from the cycle after the 4th push.
  - Release `id_allow_in`: outputs appear in order `0x80000000` … `0x8000000C`.
  - The 5th entry is accepted the cycle after the first pop.
- Streaming 20 entries with `in_valid` = `id_allow_in` = 1 every cycle: one pop per cycle, occupancy stays 1, all PCs arrive in order, and the pointers wrap 5 times with no loss.
- Full buffer plus `redirect_valid` = 1 together with `in_valid` = 1 and `id_allow_in` = 1:
  - No pop and no push occur, and `out_valid` = 0 that cycle.
  - Next cycle: `occupancy` = 0.
  - Push B (`pc=0x1c000000`): B is the next entry out, and no stale entry appears.
- `reset` asserted for one cycle with 3 entries held: all outputs return to their reset values. The next pushed entry is the first one observed.
- Random `in_valid` / `id_allow_in` / occasional `redirect_valid` for 10k cycles against a queue scoreboard. Checks:
  - In-order, exact match of `out_bus`.
  - `occupancy` equals the model count.
  - `in_allow_in` never depends on `id_allow_in` within a cycle.
